// File: rtl/pir_pkg.sv
// Shared types and defaults for the zoned PIR alarm controller.
package pir_pkg;

    // One-hot controller states.
    typedef enum logic [3:0] {
        DISARMED = 4'b0001,
        IDLE     = 4'b0010,
        ALARM    = 4'b0100,
        HOLDOFF  = 4'b1000
    } state_t;

    localparam int unsigned DEF_NUM_SENSORS     = 3;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_BUZZ_CYCLES     = 100;
    localparam int unsigned DEF_HOLDOFF_CYCLES  = 20;
    localparam int unsigned DEF_RETRIGGER       = 1;
    localparam int unsigned DEF_CNT_W           = 16;

    // Width of a counter holding values 0..bound-1, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/pir_debounce.sv
// Per-channel synchroniser and consecutive-high debounce qualifier.
module pir_debounce
    import pir_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic qual
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Metastability chain for the asynchronous sensor input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Count consecutive high cycles (saturating); qualify once the run is long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            qual <= 1'b0;
        end else begin
            if (!synced) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            qual <= synced && (cnt == CNT_MAX);
        end
    end

endmodule

// File: rtl/pir_zone_alarm.sv
// Zoned PIR alarm controller: arm/disarm, re-triggerable alarm, holdoff, zone record, event count.
module pir_zone_alarm
    import pir_pkg::*;
#(
    parameter int unsigned NUM_SENSORS     = DEF_NUM_SENSORS,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BUZZ_CYCLES     = DEF_BUZZ_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
    parameter int unsigned RETRIGGER       = DEF_RETRIGGER,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   stop_alarm,
    input  logic [NUM_SENSORS-1:0] pir_sensor,
    input  logic [NUM_SENSORS-1:0] zone_mask,
    output logic                   LED,
    output logic                   buzzer,
    output logic [NUM_SENSORS-1:0] active_zones,
    output logic [CNT_W-1:0]       event_count,
    output logic                   busy
);

    localparam int unsigned DW = cnt_width(BUZZ_CYCLES);
    localparam int unsigned HW = cnt_width(HOLDOFF_CYCLES);
    localparam logic [DW-1:0] DUR_LAST  = DW'(BUZZ_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    state_t                 state, state_nxt;
    logic [DW-1:0]          dur, dur_nxt;
    logic [HW-1:0]          hold, hold_nxt;
    logic [NUM_SENSORS-1:0] zones_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic                   led_nxt, busy_nxt;
    logic [NUM_SENSORS-1:0] qual;
    logic [NUM_SENSORS-1:0] hit;

    // One qualifier per sensor channel.
    genvar gi;
    generate
        for (gi = 0; gi < int'(NUM_SENSORS); gi++) begin : g_chan
            pir_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk (clk),
                .rst (rst),
                .din (pir_sensor[gi]),
                .qual(qual[gi])
            );
        end
    endgenerate

    assign hit = qual & zone_mask;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DISARMED;
            dur          <= '0;
            hold         <= '0;
            active_zones <= '0;
            event_count  <= '0;
            LED          <= 1'b0;
            buzzer       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            dur          <= dur_nxt;
            hold         <= hold_nxt;
            active_zones <= zones_nxt;
            event_count  <= count_nxt;
            LED          <= led_nxt;
            buzzer       <= led_nxt;
            busy         <= busy_nxt;
        end
    end

    // Next state, counter updates and output decode; disarm outranks everything.
    always_comb begin
        state_nxt = state;
        dur_nxt   = dur;
        hold_nxt  = hold;
        zones_nxt = active_zones;
        count_nxt = event_count;

        if (!arm) begin
            state_nxt = DISARMED;
        end else begin
            case (state)
                DISARMED: begin
                    state_nxt = IDLE;
                end
                IDLE: begin
                    if (|hit) begin
                        state_nxt = ALARM;
                        dur_nxt   = '0;
                        zones_nxt = hit;
                        if (event_count != {CNT_W{1'b1}}) begin
                            count_nxt = event_count + CNT_W'(1);
                        end
                    end
                end
                ALARM: begin
                    zones_nxt = active_zones | hit;
                    if (stop_alarm) begin
                        state_nxt = HOLDOFF;
                        hold_nxt  = '0;
                    end else if ((RETRIGGER != 0) && (|(hit & ~active_zones))) begin
                        dur_nxt = '0;
                    end else if (dur == DUR_LAST) begin
                        state_nxt = HOLDOFF;
                        hold_nxt  = '0;
                    end else begin
                        dur_nxt = dur + DW'(1);
                    end
                end
                HOLDOFF: begin
                    if (hold == HOLD_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        hold_nxt = hold + HW'(1);
                    end
                end
                default: begin
                    state_nxt = DISARMED;
                end
            endcase
        end

        led_nxt  = (state_nxt == ALARM);
        busy_nxt = (state_nxt == ALARM) || (state_nxt == HOLDOFF);
    end

endmodule

// File: doc/pir_zone_alarm.md
Name: pir_zone_alarm

Overview:
- Parametrised successor to the three-sensor PIR alarm controller.
- Accepts NUM_SENSORS motion inputs and synchronises and debounces each one, with a per-zone enable mask.
- Adds arm/disarm control, re-triggerable alarm duration, post-alarm holdoff, a latched record of which zones fired, and a saturating event counter.
- Drives LED, buzzer and status toward the display path.

Parameters:
- NUM_SENSORS, 3: number of PIR inputs (1..16).
- SYNC_STAGES, 2: synchroniser flops per input (>=2).
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high cycles needed to qualify a sensor (>=1).
- BUZZ_CYCLES, 100: alarm duration in cycles (>=2).
- HOLDOFF_CYCLES, 20: cycles after an alarm during which sensors are ignored (>=1).
- RETRIGGER, 1: 1 = a newly firing zone during ALARM restarts the duration counter.
- CNT_W, 16: event counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- arm  in  1  1 = armed, 0 = disarmed
- stop_alarm  in  1  operator acknowledge; level-sampled
- pir_sensor  in  NUM_SENSORS  raw asynchronous sensor inputs
- zone_mask  in  NUM_SENSORS  1 = zone enabled; quasi-static
- LED  out  1  high while in ALARM
- buzzer  out  1  high while in ALARM
- active_zones  out  NUM_SENSORS  zones that fired in the latest alarm
- event_count  out  CNT_W  number of alarms since reset, saturating
- busy  out  1  high in ALARM or HOLDOFF

Behaviour:
- Reset (rst high at a clk edge):
  - state = DISARMED; all synchroniser and debounce state cleared.
  - LED = 0, buzzer = 0, busy = 0, active_zones = 0, event_count = 0.
  - rst has priority over every other input.
- Qualification, per channel i:
  - pir_sensor[i] passes through SYNC_STAGES flops.
  - The debounce counter increments while the synchronised bit is 1 and clears to 0 when it is 0.
  - qual[i] = 1 once the bit has been high for DEBOUNCE_CYCLES consecutive cycles; it drops on the first low cycle.
  - Any high pulse shorter than DEBOUNCE_CYCLES cycles never qualifies.
- hit = qual & zone_mask.
- States use one-hot encoding: DISARMED, IDLE, ALARM, HOLDOFF.
- DISARMED:
  - Outputs LED = buzzer = busy = 0.
  - Goes to IDLE on the cycle after arm is sampled high.
  - Debounce logic keeps running so qualification is current on arming.
- IDLE:
  - If |hit, go to ALARM.
  - On entry to ALARM: active_zones <= hit; duration counter <= 0; event_count += 1, saturating at all-ones.
  - stop_alarm is ignored in IDLE.
- ALARM:
  - LED = buzzer = busy = 1, registered; they assert on the edge that enters ALARM.
  - The duration counter increments each cycle.
  - active_zones |= hit every cycle.
  - If RETRIGGER = 1 and (hit & ~active_zones) != 0, the counter reloads to 0.
  - Leave to HOLDOFF when the counter reaches BUZZ_CYCLES-1, giving exactly BUZZ_CYCLES high cycles without retrigger, or when stop_alarm = 1.
  - stop_alarm has priority over retrigger.
  - event_count does not increment on retrigger.
- HOLDOFF:
  - LED = buzzer = 0, busy = 1; hit is ignored.
  - After HOLDOFF_CYCLES cycles, go to IDLE.
  - If hit is still high on arrival in IDLE, a new alarm starts the next cycle.
- arm sampled low in any state forces DISARMED on the next edge.
  - LED and buzzer drop on that edge; the counters stop.
  - active_zones and event_count are retained.
  - Disarm has priority over stop_alarm, timeout and retrigger.
- Latency:
  - Input high and stable before edge 0 → LED high after edge SYNC_STAGES + DEBOUNCE_CYCLES + 1.
  - With default parameters this is edge 7.
- active_zones holds its value through HOLDOFF, IDLE and DISARMED until the next ALARM entry.
- Counter widths are clog2 of their bound; no wrap is reachable.

Decomposition:
- Shared package pir_pkg holds:
  - one-hot state localparams DISARMED = 4'b0001, IDLE = 4'b0010, ALARM = 4'b0100, HOLDOFF = 4'b1000;
  - default timing constants.
- Sub-module pir_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, rst, din, qual) is instantiated NUM_SENSORS times via generate.
- The FSM, counters and output registers live in pir_zone_alarm.

Test Plan:
1. Reset, arm = 1, mask = 3'b111; pulse sensor 1 high for 3 cycles → no alarm, event_count = 0. Hold sensor 1 high from edge 0 → LED/buzzer rise after edge 7 and stay high 100 cycles; active_zones = 3'b010; event_count = 1; busy stays high 20 more cycles.
2. Alarm active on zone 0; zone 2 qualifies at alarm cycle 60 with RETRIGGER = 1 → counter restarts, LED high 160 cycles total; active_zones = 3'b101; event_count = 1.
3. stop_alarm asserted at alarm cycle 10, same cycle as a new zone qualifies → HOLDOFF next edge, LED = 0; after 20 cycles IDLE; sensor still high → second alarm, event_count = 2.
4. zone_mask = 3'b011, sensor 2 held high → no alarm. Set mask bit 2 → alarm 1 cycle after hit rises, active_zones = 3'b100.
5. arm dropped mid-ALARM → LED/buzzer/busy 0 next edge, state DISARMED, active_zones retained. rst asserted mid-HOLDOFF → all outputs 0 and event_count = 0 next edge.
6. CNT_W = 2; trigger 5 alarms → event_count = 3, saturated.
